// File: rtl/lc_pkg.sv
// -----------------------------------------------------------------------------
// lc_pkg
// Shared sizing constants and helpers for the local-coincidence detector.
//   N_CHAN    : number of discriminator channels
//   WIN_WIDTH : width of the window length setting and per-channel counters
//   THR_WIDTH : width of the coincidence threshold and active-channel count
//               (2**THR_WIDTH must exceed N_CHAN so the count never wraps)
//   popcount  : number of set bits in an N_CHAN-wide vector, THR_WIDTH bits
// -----------------------------------------------------------------------------
package lc_pkg;

  localparam int N_CHAN    = 24;
  localparam int WIN_WIDTH = 8;
  localparam int THR_WIDTH = 5;

  function automatic logic [THR_WIDTH-1:0] popcount(input logic [N_CHAN-1:0] v);
    logic [THR_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      n = n + {{(THR_WIDTH-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lc_window_ctr.sv
// -----------------------------------------------------------------------------
// lc_window_ctr
// Single-channel coincidence window. A trigger loads the counter with W-1
// (W = max(width, 1)) and the window reads open on the trigger cycle itself
// plus every following cycle in which the counter is non-zero, giving exactly
// W open cycles. A trigger inside an open window reloads and so extends it.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the counter
//   trig  : discriminator trigger pulse (a held level retriggers every cycle)
//   width : window length in cycles, 0 is treated as 1
//   open  : window open this cycle (combinational)
// -----------------------------------------------------------------------------
module lc_window_ctr
  import lc_pkg::*;
#(
  parameter int P_WIN_WIDTH = WIN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trig,
  input  logic [P_WIN_WIDTH-1:0] width,
  output logic                   open
);

  logic [P_WIN_WIDTH-1:0] cnt;
  logic [P_WIN_WIDTH-1:0] reload;

  // The trigger cycle already counts as open, so the counter only has to
  // cover the remaining W-1 cycles; width 0 behaves like width 1.
  always_comb begin
    reload = '0;
    if (width != '0) begin
      reload = width - P_WIN_WIDTH'(1);
    end
  end

  // Down-counter that saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= reload;
    end else if (cnt != '0) begin
      cnt <= cnt - P_WIN_WIDTH'(1);
    end
  end

  assign open = trig | (cnt != '0);

endmodule

// File: rtl/lc_window_detector.sv
// -----------------------------------------------------------------------------
// lc_window_detector
// Multi-channel local-coincidence detector for the mDOM digitizer front end.
// Every channel runs its own coincidence window; a channel is flagged while
// its window is open and at least n_lc_thr channels have open windows in the
// same cycle. The flag is registered, one clock after the triggering edge.
// Ports:
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset
//   trig            : per-channel trigger pulses [P_N_CHAN]
//   lc_window_width : window length in cycles (0 treated as 1), quasi-static
//   n_lc_thr        : minimum number of open windows, quasi-static
//   local_coinc     : registered per-channel coincidence flag [P_N_CHAN]
//   lc_nact         : registered open-window count, only when LC_NACT_OUT_EN
//                     is defined (diagnostics / header multiplicity field)
// Optional feature macro: LC_NACT_OUT_EN
// Note: the active count is built with the package popcount, so overriding
// P_N_CHAN or P_THR_WIDTH beyond the package constants needs lc_pkg updated.
// -----------------------------------------------------------------------------
module lc_window_detector
  import lc_pkg::*;
#(
  parameter int P_N_CHAN    = N_CHAN,
  parameter int P_WIN_WIDTH = WIN_WIDTH,
  parameter int P_THR_WIDTH = THR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_N_CHAN-1:0]    trig,
  input  logic [P_WIN_WIDTH-1:0] lc_window_width,
  input  logic [P_THR_WIDTH-1:0] n_lc_thr,
  output logic [P_N_CHAN-1:0]    local_coinc
`ifdef LC_NACT_OUT_EN
  ,
  output logic [P_THR_WIDTH-1:0] lc_nact
`endif
);

  logic [P_N_CHAN-1:0]    win_open;
  logic [P_THR_WIDTH-1:0] nact;
  logic                   coinc_ok;

  for (genvar i = 0; i < P_N_CHAN; i++) begin : g_chan
    lc_window_ctr #(
      .P_WIN_WIDTH (P_WIN_WIDTH)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig[i]),
      .width (lc_window_width),
      .open  (win_open[i])
    );
  end

  // A threshold above the channel count can never be met, so the flags stay
  // low; a threshold of zero flags every open window.
  assign nact     = P_THR_WIDTH'(popcount(N_CHAN'(win_open)));
  assign coinc_ok = (nact >= n_lc_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      local_coinc <= '0;
    end else begin
      local_coinc <= coinc_ok ? win_open : '0;
    end
  end

`ifdef LC_NACT_OUT_EN
  // Multiplicity is registered alongside the flags so both describe the
  // same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_nact <= '0;
    end else begin
      lc_nact <= nact;
    end
  end
`endif

endmodule

// File: tb/tb_lc_window_detector.sv
// -----------------------------------------------------------------------------
// tb_lc_window_detector
// Self-checking bench for lc_window_detector. Cycle numbers count rising
// edges after reset release; trig applied before edge c produces its flag in
// cycle c+1, which is sampled 1 time unit after that edge.
// Optional feature macro: LC_NACT_OUT_EN (also checks lc_nact when defined)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc_window_detector;

  logic        clk;
  logic        rst_n;
  logic [23:0] trig;
  logic [7:0]  lc_window_width;
  logic [4:0]  n_lc_thr;
  logic [23:0] local_coinc;
`ifdef LC_NACT_OUT_EN
  logic [4:0]  lc_nact;
`endif

  int cyc;
  int checkCount;
  int passCount;

  typedef struct {
    logic [23:0] trig;
    logic [7:0]  width;
    logic [4:0]  thr;
    logic [23:0] expFlags;
    logic [4:0]  expNact;
  } vec_t;

  vec_t vecs[$];

  lc_window_detector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trig            (trig),
    .lc_window_width (lc_window_width),
    .n_lc_thr        (n_lc_thr),
    .local_coinc     (local_coinc)
`ifdef LC_NACT_OUT_EN
    ,
    .lc_nact         (lc_nact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of triggers, let the edge happen, sample just after it.
  task automatic applyStimulus(input logic [23:0] t);
    trig = t;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [23:0] expFlags);
    checkCount++;
    if (local_coinc !== expFlags) begin
      $display("[TB] FAIL %s cyc=%0d local_coinc=%h expected=%h", name, cyc, local_coinc, expFlags);
    end else begin
      passCount++;
    end
  endtask

`ifdef LC_NACT_OUT_EN
  task automatic checkNact(input string name, input logic [4:0] expNact);
    checkCount++;
    if (lc_nact !== expNact) begin
      $display("[TB] FAIL %s cyc=%0d lc_nact=%0d expected=%0d", name, cyc, lc_nact, expNact);
    end else begin
      passCount++;
    end
  endtask
`endif

  initial begin
    logic [23:0] t;
    logic [23:0] e;

    checkCount = 0;
    passCount  = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    trig       = '0;
    lc_window_width = 8'd14;
    n_lc_thr   = 5'd1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 24'h000000);
`ifdef LC_NACT_OUT_EN
    checkNact("reset_nact", 5'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // thr=1, W=14: trig[5]@10 self-coincident for cycles 11..24 only.
    while (cyc < 31) begin
      t = (cyc == 10) ? 24'h000020 : 24'h000000;
      applyStimulus(t);
      e = (cyc >= 11 && cyc <= 24) ? 24'h000020 : 24'h000000;
      checkOutput("thr1_single", e);
    end

    // thr=2: a lone trig[0]@169 never coincides.
    n_lc_thr = 5'd2;
    while (cyc < 190) begin
      t = (cyc == 169) ? 24'h000001 : 24'h000000;
      applyStimulus(t);
      checkOutput("thr2_lone", 24'h000000);
    end

    // trig[0]@199, trig[1]@213 miss; trig[0]@215 overlaps ch1 window 213..226.
    while (cyc < 240) begin
      t = 24'h000000;
      if (cyc == 199 || cyc == 215) t[0] = 1'b1;
      if (cyc == 213) t[1] = 1'b1;
      applyStimulus(t);
      e = (cyc >= 216 && cyc <= 227) ? 24'h000003 : 24'h000000;
      checkOutput("thr2_pair", e);
    end

    // trig[0] held from 300 to 329, trig[4]@305 -> both open 305..318.
    while (cyc < 350) begin
      t = 24'h000000;
      if (cyc >= 300 && cyc < 330) t[0] = 1'b1;
      if (cyc == 305) t[4] = 1'b1;
      applyStimulus(t);
      e = (cyc >= 306 && cyc <= 319) ? 24'h000011 : 24'h000000;
      checkOutput("held_trig", e);
    end

    // Short-window and threshold corner cases, one record per cycle.
    // Retrigger extends a W=4 window: open t0..t0+5.
    vecs.push_back('{24'h000100, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000000, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000100, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000000, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000000, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000000, 8'd4, 5'd1, 24'h000100, 5'd1});
    vecs.push_back('{24'h000000, 8'd4, 5'd1, 24'h000000, 5'd0});
    // W=0 acts as 1: same-cycle pair coincides, staggered pair does not.
    vecs.push_back('{24'h000000, 8'd0, 5'd2, 24'h000000, 5'd0});
    vecs.push_back('{24'h00000C, 8'd0, 5'd2, 24'h00000C, 5'd2});
    vecs.push_back('{24'h000000, 8'd0, 5'd2, 24'h000000, 5'd0});
    vecs.push_back('{24'h000004, 8'd0, 5'd2, 24'h000000, 5'd1});
    vecs.push_back('{24'h000008, 8'd0, 5'd2, 24'h000000, 5'd1});
    vecs.push_back('{24'h000000, 8'd0, 5'd2, 24'h000000, 5'd0});
    // Three simultaneous triggers meet thr=3.
    vecs.push_back('{24'h000007, 8'd1, 5'd3, 24'h000007, 5'd3});
    vecs.push_back('{24'h000000, 8'd1, 5'd3, 24'h000000, 5'd0});
    // thr=0: flagged for the whole W=3 window.
    vecs.push_back('{24'h000010, 8'd3, 5'd0, 24'h000010, 5'd1});
    vecs.push_back('{24'h000000, 8'd3, 5'd0, 24'h000010, 5'd1});
    vecs.push_back('{24'h000000, 8'd3, 5'd0, 24'h000010, 5'd1});
    vecs.push_back('{24'h000000, 8'd3, 5'd0, 24'h000000, 5'd0});
    // thr=25 above channel count: never flagged even with all open.
    vecs.push_back('{24'hFFFFFF, 8'd3, 5'd25, 24'h000000, 5'd24});
    vecs.push_back('{24'h000000, 8'd3, 5'd25, 24'h000000, 5'd24});
    vecs.push_back('{24'h000000, 8'd3, 5'd25, 24'h000000, 5'd24});
    vecs.push_back('{24'h000000, 8'd3, 5'd25, 24'h000000, 5'd0});
    // thr=24 with every channel open.
    vecs.push_back('{24'hFFFFFF, 8'd2, 5'd24, 24'hFFFFFF, 5'd24});
    vecs.push_back('{24'h000000, 8'd2, 5'd24, 24'hFFFFFF, 5'd24});
    vecs.push_back('{24'h000000, 8'd2, 5'd24, 24'h000000, 5'd0});
    // Width shrinks mid-window: the running W=5 windows are unaffected.
    vecs.push_back('{24'h0000C0, 8'd5, 5'd2, 24'h0000C0, 5'd2});
    vecs.push_back('{24'h000000, 8'd2, 5'd2, 24'h0000C0, 5'd2});
    vecs.push_back('{24'h000000, 8'd2, 5'd2, 24'h0000C0, 5'd2});
    vecs.push_back('{24'h000000, 8'd2, 5'd2, 24'h0000C0, 5'd2});
    vecs.push_back('{24'h000000, 8'd2, 5'd2, 24'h0000C0, 5'd2});
    vecs.push_back('{24'h000000, 8'd2, 5'd2, 24'h000000, 5'd0});

    foreach (vecs[i]) begin
      lc_window_width = vecs[i].width;
      n_lc_thr        = vecs[i].thr;
      applyStimulus(vecs[i].trig);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFlags);
`ifdef LC_NACT_OUT_EN
      checkNact($sformatf("vec%0d_nact", i), vecs[i].expNact);
`endif
    end

    // Asynchronous reset in the middle of an active coincidence.
    lc_window_width = 8'd14;
    n_lc_thr        = 5'd2;
    applyStimulus(24'h000003);
    checkOutput("pre_reset_hit", 24'h000003);
    repeat (3) begin
      applyStimulus(24'h000000);
      checkOutput("pre_reset_hold", 24'h000003);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 24'h000000);
`ifdef LC_NACT_OUT_EN
    checkNact("async_reset_nact", 5'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(24'h000000);
    checkOutput("post_reset_cleared", 24'h000000);
    applyStimulus(24'h00000C);
    checkOutput("post_reset_hit", 24'h00000C);
    applyStimulus(24'h000000);
    checkOutput("post_reset_hold", 24'h00000C);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
